sort_ctrl: RTL
==============

// Module: sort_ctrl
// PURPOSE
//  Sequencing controller for the in-place sort engine: bubble-sorts DEPTH words held in the
//  single-port sort RAM, ascending and unsigned, with early exit on a swap-free pass.
//  Sits between top-level start/done and the RAM port; drives RAM address, write enable and data.
// PARAMETERS
//  WIDTH   8   data word width (bits)
//  DEPTH   8   words to sort, addresses 0..DEPTH-1; DEPTH>=2 (elaboration error otherwise)
//  ADDR_W  $clog2(DEPTH)   RAM address width (derived, not overridden)
// PORTS
//  clk        in   1        system clock, all state on rising edge
//  rst        in   1        synchronous reset, ACTIVE-LOW (rst==0 at a clk edge resets)
//  s          in   1        start request, sampled only in IDLE
//  busy       out  1        high while a sort is in progress (state != IDLE)
//  done       out  1        high from sort completion until next accepted s or reset
//  swap_cnt   out  16       swaps performed in current/last sort, saturating at 16'hFFFF
//  ram_addr   out  ADDR_W   RAM address
//  ram_we     out  1        RAM write enable
//  ram_wdata  out  WIDTH    RAM write data
//  ram_rdata  in   WIDTH    RAM read data, valid the cycle after ram_addr presented (1-cycle sync read)
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE, busy=0, done=0, swap_cnt=0, ram_addr=0, ram_we=0,
//   ram_wdata=0, internal i/p/swapped/a/b=0. Mid-sort reset aborts at once; RAM keeps partial order.
//  ram_we is 1 ONLY in WR_A/WR_B; all outputs registered-state decoded, no combinational s->output path.
//  FSM (i=inner index, p=pass index):
//   IDLE : ram_addr=0. s==1 -> RD_A with i=0,p=0,swapped=0,swap_cnt=0,done=0. s==0 -> stay.
//   RD_A : ram_addr=i -> RD_B.
//   RD_B : ram_addr=i+1; a<=ram_rdata (word i) -> CMP.
//   CMP  : b<=ram_rdata (word i+1); a>ram_rdata -> WR_A, else -> NEXT (equal: no swap, stable).
//   WR_A : ram_addr=i,   ram_we=1, ram_wdata=b -> WR_B.
//   WR_B : ram_addr=i+1, ram_we=1, ram_wdata=a; swapped<=1; swap_cnt++ (saturating) -> NEXT.
//   NEXT : i<DEPTH-2-p -> i++, RD_A.
//          i==DEPTH-2-p and (swapped==0 or p==DEPTH-2) -> IDLE, done<=1.
//          else -> p++, i=0, swapped=0, RD_A.
//  Timing: compare without swap = 4 cycles, with swap = 6 cycles; done visible the cycle after the
//   final NEXT. s while busy is ignored; s in the same edge done rises is ignored (not in IDLE yet).
//  s held high continuously: after done, next edge in IDLE restarts (done clears, re-sorts sorted data).
//  Index arithmetic in ADDR_W+1 bits; i+1 never exceeds DEPTH-1; no address wrap.
// STRUCTURE
//  sort_pkg: state_t enum {IDLE,RD_A,RD_B,CMP,WR_A,WR_B,NEXT}; SWAP_CNT_W=16 constant.
//  One sub-module: sort_cmp_swap (a/b holding registers + unsigned a>b comparator, WIDTH-param).
//  FSM, i/p counters, swapped flag, swap_cnt in sort_ctrl. Target 150-250 lines total.
// TESTING (bench with behavioural 1-cycle-read RAM, DEPTH=8, WIDTH=8, compare mem to reference model)
//  1 sorted {0..7}, pulse s -> done rises exactly 28 cycles after s edge; swap_cnt=0; ram_we never 1.
//  2 reversed {7..0} -> mem={0..7}; swap_cnt=28; done at 168 cycles (7 passes, all compares swap).
//  3 {5,5,3,3,9,0,9,1} -> {0,1,3,3,5,5,9,9}; equal pairs never written (ram_we monitor on ties).
//  4 s pulsed again at cycle 10 of a sort -> ignored; result/timing identical to undisturbed run.
//  5 rst=0 for 1 cycle at cycle 20 of reversed sort -> next cycle busy=0,done=0,swap_cnt=0,ram_we=0;
//    new s then completes sort correctly from partial RAM state.
//  6 {255,0,128,1,254,2,127,3} -> unsigned ascending {0,1,2,3,127,128,254,255}; done held until next s.

Source files
------------

// File: rtl/sort_pkg.sv
// +-----------------------------------------------------------------+
// | sort_pkg : shared types and constants for the bubble-sort engine |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package sort_pkg;

  localparam int SWAP_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    CMP  = 3'd3,
    WR_A = 3'd4,
    WR_B = 3'd5,
    NEXT = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sort_cmp_swap.sv
// +-----------------------------------------------------------------+
// | sort_cmp_swap : a/b holding registers and unsigned a > din check |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module sort_cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_a,
  input  logic             i_load_b,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_a_gt_din
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (i_load_a) r_a <= i_din;
      if (i_load_b) r_b <= i_din;
    end
  end

  // Compared against the live read data so the swap decision is made in CMP itself.
  assign o_a_gt_din = (r_a > i_din);
  assign o_a        = r_a;
  assign o_b        = r_b;

endmodule

`default_nettype wire

// File: rtl/sort_ctrl.sv
// +-----------------------------------------------------------------+
// | sort_ctrl : in-place ascending bubble sort over a 1-port RAM     |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module sort_ctrl
  import sort_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_CNT_W-1:0] swap_cnt,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata
);

  generate
    if (DEPTH < 2) begin : g_depth_chk
      $error("sort_ctrl: DEPTH must be at least 2");
    end
  endgenerate

  localparam logic [ADDR_W:0] c_last_max = (ADDR_W + 1)'(DEPTH - 2);

  state_t          r_state;
  logic [ADDR_W:0] r_i;
  logic [ADDR_W:0] r_p;
  logic            r_swapped;

  logic [ADDR_W:0] w_i_inc;
  logic [ADDR_W:0] w_last_i;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic            w_gt;

  assign w_i_inc  = r_i + 1'b1;
  assign w_last_i = c_last_max - r_p;

  sort_cmp_swap #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .i_load_a   (r_state == RD_B),
    .i_load_b   (r_state == CMP),
    .i_din      (ram_rdata),
    .o_a        (w_a),
    .o_b        (w_b),
    .o_a_gt_din (w_gt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_p       <= '0;
      r_swapped <= 1'b0;
      done      <= 1'b0;
      swap_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s) begin
            r_state   <= RD_A;
            r_i       <= '0;
            r_p       <= '0;
            r_swapped <= 1'b0;
            swap_cnt  <= '0;
            done      <= 1'b0;
          end
        end
        RD_A: r_state <= RD_B;
        RD_B: r_state <= CMP;
        CMP:  r_state <= w_gt ? WR_A : NEXT;
        WR_A: r_state <= WR_B;
        WR_B: begin
          r_swapped <= 1'b1;
          if (swap_cnt != '1) swap_cnt <= swap_cnt + 1'b1;
          r_state <= NEXT;
        end
        NEXT: begin
          if (r_i < w_last_i) begin
            r_i     <= w_i_inc;
            r_state <= RD_A;
          end else if (!r_swapped || (r_p == c_last_max)) begin
            done    <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_p       <= r_p + 1'b1;
            r_i       <= '0;
            r_swapped <= 1'b0;
            r_state   <= RD_A;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM port is a pure decode of registered state and index; s never reaches it.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (r_state)
      RD_A: ram_addr = r_i[ADDR_W-1:0];
      RD_B: ram_addr = w_i_inc[ADDR_W-1:0];
      WR_A: begin
        ram_addr  = r_i[ADDR_W-1:0];
        ram_we    = 1'b1;
        ram_wdata = w_b;
      end
      WR_B: begin
        ram_addr  = w_i_inc[ADDR_W-1:0];
        ram_we    = 1'b1;
        ram_wdata = w_a;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE);

endmodule

`default_nettype wire
